regfile_writeback_arbiter: RTL

- Writer side of the 32x32 register file. Merges single-cycle ALU results with long-latency results (loads, multiply/divide) onto the file's single write port (reg_write / write_reg / write_data).
- Buffers long-latency returns in a small FIFO.
- Keeps a scoreboard of destination registers with results outstanding, and flags read-after-write hazards to the issue stage.
- Sits between execute/memory stages and the register file.

---
 rtl/regfile_writeback_arbiter_if.sv | 52 +++++
 rtl/regfile_writeback_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter_if.sv
// Signal bundle between the execute/memory/issue stages and the register-file writeback arbiter.
// The master side drives results and issue information; the slave side is the arbiter.
interface regfile_writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_reg;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  ld_issue;
    logic [ADDR_WIDTH-1:0] ld_issue_reg;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_reg;
    logic [DATA_WIDTH-1:0] ld_data;

    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic                  hazard;

    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;

    logic [COUNT_W-1:0]    fifo_count;
    logic                  err_waw;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_issue, ld_issue_reg,
        output ld_valid, ld_reg, ld_data,
        output read_reg1, read_reg2,
        input  ld_ready, hazard,
        input  reg_write, write_reg, write_data,
        input  fifo_count, err_waw
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_issue, ld_issue_reg,
        input  ld_valid, ld_reg, ld_data,
        input  read_reg1, read_reg2,
        output ld_ready, hazard,
        output reg_write, write_reg, write_data,
        output fifo_count, err_waw
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port,
// buffering long-latency returns and tracking pending destinations for hazard detection.
module regfile_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_writeback_arbiter_if.slave  bus
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int COUNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_reg  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [COUNT_W-1:0]    count;

    logic                  ready;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_reg;
    logic [DATA_WIDTH-1:0] head_data;

    logic [NUM_REGS-1:0]   sb;
    logic [NUM_REGS-1:0]   sb_next;
    logic                  waw_hit;

    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] write_reg_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic                  err_waw_q;

    // Space is judged on the current count only; a same-cycle pop never makes room for a push.
    assign ready      = (count < DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = bus.ld_valid && ready;
    assign pop        = !bus.alu_valid && !fifo_empty;
    assign head_reg   = fifo_reg[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= bus.ld_reg;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear is applied before set so an issue to the register being retired keeps it pending.
    always_comb begin
        sb_next = sb;
        if (pop) begin
            sb_next[head_reg] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_reg != '0)) begin
            sb_next[bus.ld_issue_reg] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    assign waw_hit = bus.ld_issue && sb[bus.ld_issue_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            sb        <= '0;
            err_waw_q <= 1'b0;
        end else begin
            sb <= sb_next;
            if (waw_hit) begin
                err_waw_q <= 1'b1;
            end
        end
    end

    // ALU results always win the port; index and data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (bus.alu_valid) begin
            reg_write_q  <= (bus.alu_reg != '0);
            write_reg_q  <= bus.alu_reg;
            write_data_q <= bus.alu_data;
        end else if (pop) begin
            reg_write_q  <= (head_reg != '0);
            write_reg_q  <= head_reg;
            write_data_q <= head_data;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

    assign bus.ld_ready   = ready;
    assign bus.fifo_count = count;
    assign bus.hazard     = ((bus.read_reg1 != '0) && sb[bus.read_reg1]) ||
                            ((bus.read_reg2 != '0) && sb[bus.read_reg2]);
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.err_waw    = err_waw_q;
endmodule
